// File: rtl/alu_issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_unit_pkg
//   Shared definitions for the ALU issue stage: the opcodes understood by
//   sixteen_bit_alu and the 2-bit encodings of the issue FSM.
//   No ports; import with "import alu_issue_unit_pkg::*;".
// -----------------------------------------------------------------------------
package alu_issue_unit_pkg;

   // ALU opcodes, passed unchanged onto ALUCtrl
   localparam logic [3:0] ALU_SUB = 4'h0;
   localparam logic [3:0] ALU_ADD = 4'h1;
   localparam logic [3:0] ALU_OR  = 4'h2;
   localparam logic [3:0] ALU_AND = 4'h3;
   localparam logic [3:0] ALU_DEC = 4'h4;
   localparam logic [3:0] ALU_INC = 4'h5;
   localparam logic [3:0] ALU_INV = 4'h6;
   localparam logic [3:0] ALU_SLA = 4'h7;
   localparam logic [3:0] ALU_SRA = 4'h8;
   localparam logic [3:0] ALU_SLL = 4'h9;
   localparam logic [3:0] ALU_SRL = 4'hA;
   localparam logic [3:0] ALU_SLE = 4'hB;

   // Issue FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;
   localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/alu_issue_unit_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
//   NREGS x WIDTH register file with two asynchronous operand read ports, an
//   asynchronous debug read port and one synchronous write port. R0 is
//   hardwired to zero: it is cleared by reset and never written.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   we_i/waddr_i/wdata_i write port (write to address 0 is dropped)
//   raddr_a_i/rdata_a_o  operand A read port
//   raddr_b_i/rdata_b_o  operand B read port
//   raddr_dbg_i/rdata_dbg_o debug read port
// -----------------------------------------------------------------------------
module alu_regfile #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [WIDTH-1:0]  rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [WIDTH-1:0]  rdata_b_o,
   input  logic [REG_AW-1:0] raddr_dbg_i,
   output logic [WIDTH-1:0]  rdata_dbg_o
);

   logic [WIDTH-1:0] mem_q [NREGS];

   // mem_q[0] is only ever touched by reset, so it always reads as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o   = mem_q[raddr_a_i];
   assign rdata_b_o   = mem_q[raddr_b_i];
   assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//   Issue stage in front of the combinational sixteen_bit_alu. Accepts one
//   register-form instruction at a time (IDLE -> READ -> EXEC -> WB), reads
//   operands from the internal register file, drives A/B/ALUCtrl, captures the
//   ALU result in EXEC and writes it back / publishes it in WB.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   instr_valid/instr_ready   instruction handshake (ready only in IDLE)
//   instr_op/rd/rs/rt         opcode and register fields
//   A, B, ALUCtrl             registered ALU operands and opcode
//   S, Overflow, Zero         ALU outputs
//   res_valid/res_data/res_rd one-cycle result pulse, last result and target
//   sticky_ovf, clr_flags     sticky overflow flag and its synchronous clear
//   dbg_addr/dbg_data         combinational register file peek
// -----------------------------------------------------------------------------
module alu_issue_unit
   import alu_issue_unit_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs,
   input  logic [REG_AW-1:0] instr_rt,
   output logic [WIDTH-1:0]  A,
   output logic [WIDTH-1:0]  B,
   output logic [3:0]        ALUCtrl,
   input  logic [WIDTH-1:0]  S,
   input  logic              Overflow,
   input  logic              Zero,
   output logic              res_valid,
   output logic [WIDTH-1:0]  res_data,
   output logic [REG_AW-1:0] res_rd,
   output logic              sticky_ovf,
   input  logic              clr_flags,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [WIDTH-1:0]  dbg_data
);

   logic [1:0]        state_q, state_d;
   logic [3:0]        op_q;
   logic [REG_AW-1:0] rd_q, rs_q, rt_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [3:0]        ctrl_q;
   logic [WIDTH-1:0]  s_hold_q;
   logic              ovf_hold_q, zero_hold_q;
   logic              res_valid_q;
   logic [WIDTH-1:0]  res_data_q;
   logic [REG_AW-1:0] res_rd_q;
   logic              sticky_q, sticky_d;

   logic              accept;
   logic              wb_we;
   logic [WIDTH-1:0]  rf_rdata_a, rf_rdata_b;

   assign instr_ready = (state_q == ST_IDLE);
   assign accept      = instr_valid && instr_ready;
   assign wb_we       = (state_q == ST_WB);

   alu_regfile #(
      .WIDTH  (WIDTH),
      .NREGS  (NREGS),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .we_i        (wb_we),
      .waddr_i     (rd_q),
      .wdata_i     (s_hold_q),
      .raddr_a_i   (rs_q),
      .rdata_a_o   (rf_rdata_a),
      .raddr_b_i   (rt_q),
      .rdata_b_o   (rf_rdata_b),
      .raddr_dbg_i (dbg_addr),
      .rdata_dbg_o (dbg_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_READ;
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // An overflowing writeback beats a coincident clear
   always_comb begin
      sticky_d = sticky_q;
      if (clr_flags) sticky_d = 1'b0;
      if (wb_we && ovf_hold_q) sticky_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         rd_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ctrl_q      <= '0;
         s_hold_q    <= '0;
         ovf_hold_q  <= 1'b0;
         zero_hold_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sticky_q    <= sticky_d;
         res_valid_q <= wb_we;
         if (accept) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            rs_q <= instr_rs;
            rt_q <= instr_rt;
         end
         if (state_q == ST_READ) begin
            a_q    <= rf_rdata_a;
            b_q    <= rf_rdata_b;
            ctrl_q <= op_q;
         end
         if (state_q == ST_EXEC) begin
            s_hold_q    <= S;
            ovf_hold_q  <= Overflow;
            zero_hold_q <= Zero;
         end
         // res_data shows the ALU result even when the R0 write is dropped
         if (wb_we) begin
            res_data_q <= s_hold_q;
            res_rd_q   <= rd_q;
         end
      end
   end

   // Zero is held for completeness only; nothing downstream consumes it
   logic unused_zero_hold;
   assign unused_zero_hold = zero_hold_q;

   assign A          = a_q;
   assign B          = b_q;
   assign ALUCtrl    = ctrl_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_rd     = res_rd_q;
   assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
   import alu_issue_unit_pkg::*;

   logic        clk, rst;
   logic        instr_valid, instr_ready;
   logic [3:0]  instr_op;
   logic [2:0]  instr_rd, instr_rs, instr_rt;
   logic [15:0] A, B, S;
   logic [3:0]  ALUCtrl;
   logic        Overflow, Zero;
   logic        res_valid;
   logic [15:0] res_data;
   logic [2:0]  res_rd;
   logic        sticky_ovf, clr_flags;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: architectural registers and the sticky flag
   logic [15:0] mreg [8];
   logic        msticky;

   alu_issue_unit #(
      .WIDTH  (16),
      .NREGS  (8),
      .REG_AW (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs    (instr_rs),
      .instr_rt    (instr_rt),
      .A           (A),
      .B           (B),
      .ALUCtrl     (ALUCtrl),
      .S           (S),
      .Overflow    (Overflow),
      .Zero        (Zero),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .sticky_ovf  (sticky_ovf),
      .clr_flags   (clr_flags),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // Behavioural stand-in for sixteen_bit_alu: returns {overflow, result}
   function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      int          sa, sb, r;
      logic [15:0] s;
      logic        v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = 0;
      s  = '0;
      v  = 1'b0;
      case (op)
         ALU_SUB: begin r = sa - sb; s = 16'(r); v = (r > 32767) || (r < -32768); end
         ALU_ADD: begin r = sa + sb; s = 16'(r); v = (r > 32767) || (r < -32768); end
         ALU_OR:  s = a | b;
         ALU_AND: s = a & b;
         ALU_DEC: begin r = sa - 1; s = 16'(r); v = (r < -32768); end
         ALU_INC: begin r = sa + 1; s = 16'(r); v = (r > 32767); end
         ALU_INV: s = ~a;
         ALU_SLA: begin r = sa * 2; s = 16'(r); v = (r > 32767) || (r < -32768); end
         ALU_SRA: s = 16'(sa >>> 1);
         ALU_SLL: s = 16'(int'(a) * 2);
         ALU_SRL: s = a / 16'd2;
         ALU_SLE: s = (sa <= sb) ? 16'd1 : 16'd0;
         default: s = '0;
      endcase
      return {v, s};
   endfunction

   logic [16:0] alu_out;
   assign alu_out  = alu_f(ALUCtrl, A, B);
   assign S        = alu_out[15:0];
   assign Overflow = alu_out[16];
   assign Zero     = (alu_out[15:0] == 16'h0000);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_dbg(input logic [2:0] addr, input string tag);
      dbg_addr = addr;
      #1;
      chk(tag, {16'h0, dbg_data}, {16'h0, mreg[addr]});
   endtask

   // Issues one instruction, checks the 4-cycle timeline and the result.
   // With noise set, instr_valid and fields are scrambled while the unit is busy.
   task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input bit noise);
      logic [16:0] r;
      int          waited;
      instr_valid = 1'b1;
      instr_op    = op;
      instr_rd    = rd;
      instr_rs    = rs;
      instr_rt    = rt;
      waited      = 0;
      while (!instr_ready && waited < 20) begin
         tick();
         waited++;
      end
      chk("ready_before_accept", {31'h0, instr_ready}, 32'h1);
      if (!instr_ready) begin
         instr_valid = 1'b0;
         return;
      end
      r = alu_f(op, mreg[rs], mreg[rt]);
      tick();
      instr_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (noise) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_op    = 4'($urandom);
            instr_rd    = 3'($urandom);
            instr_rs    = 3'($urandom);
            instr_rt    = 3'($urandom);
         end
         chk("busy_not_ready", {31'h0, instr_ready}, 32'h0);
         chk("busy_no_result", {31'h0, res_valid}, 32'h0);
         tick();
      end
      instr_valid = 1'b0;
      if (rd != 3'd0) mreg[rd] = r[15:0];
      if (r[16]) msticky = 1'b1;
      else if (clr_flags) msticky = 1'b0;
      chk("res_valid_at_latency", {31'h0, res_valid}, 32'h1);
      chk("res_data", {16'h0, res_data}, {16'h0, r[15:0]});
      chk("res_rd", {29'h0, res_rd}, {29'h0, rd});
      chk("sticky_ovf", {31'h0, sticky_ovf}, {31'h0, msticky});
      chk("ready_after_wb", {31'h0, instr_ready}, 32'h1);
      chk_dbg(rd, "dbg_after_wb");
   endtask

   int ready_low;

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr_op    = '0;
      instr_rd    = '0;
      instr_rs    = '0;
      instr_rt    = '0;
      clr_flags   = 1'b0;
      dbg_addr    = '0;
      msticky     = 1'b0;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      tick();
      tick();
      chk("rst_ready", {31'h0, instr_ready}, 32'h1);
      chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
      chk("rst_res_data", {16'h0, res_data}, 32'h0);
      chk("rst_abc", {12'h0, A, ALUCtrl}, 32'h0);
      chk("rst_b", {16'h0, B}, 32'h0);
      chk("rst_sticky", {31'h0, sticky_ovf}, 32'h0);
      rst = 1'b0;
      tick();

      // Reset in the middle of EXEC aborts without writeback
      for (int i = 0; i < 5; i++) do_instr(ALU_INC, 3'd1, 3'd1, 3'd0, 1'b0);
      chk("preload_r1", {16'h0, mreg[1]}, 32'h5);
      instr_valid = 1'b1;
      instr_op    = ALU_ADD;
      instr_rd    = 3'd3;
      instr_rs    = 3'd1;
      instr_rt    = 3'd1;
      tick();
      instr_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_ready", {31'h0, instr_ready}, 32'h1);
      chk("midrst_res_valid", {31'h0, res_valid}, 32'h0);
      chk("midrst_a", {16'h0, A}, 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      msticky = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("midrst_no_wb", {31'h0, res_valid}, 32'h0);
         tick();
      end
      for (int i = 0; i < 8; i++) chk_dbg(3'(i), "midrst_regs_zero");

      // Preload R1=5, R2=3 and add
      for (int i = 0; i < 5; i++) do_instr(ALU_INC, 3'd1, 3'd1, 3'd0, 1'b0);
      for (int i = 0; i < 3; i++) do_instr(ALU_INC, 3'd2, 3'd2, 3'd0, 1'b0);
      do_instr(ALU_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
      chk("add_r3_const", {16'h0, res_data}, 32'h8);

      // Back-to-back RAW with instr_valid held high
      instr_valid = 1'b1;
      instr_op    = ALU_SUB;
      instr_rd    = 3'd5;
      instr_rs    = 3'd1;
      instr_rt    = 3'd2;
      chk("b2b_ready1", {31'h0, instr_ready}, 32'h1);
      tick();
      instr_op  = ALU_ADD;
      instr_rd  = 3'd6;
      instr_rs  = 3'd5;
      instr_rt  = 3'd5;
      ready_low = 0;
      while (!instr_ready && ready_low < 10) begin
         ready_low++;
         tick();
      end
      chk("b2b_ready_low_cycles", ready_low, 32'd3);
      chk("b2b_sub_result", {16'h0, res_data}, 32'h2);
      mreg[5] = 16'h0002;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      tick();
      mreg[6] = 16'(mreg[5] + mreg[5]);
      chk("b2b_add_valid", {31'h0, res_valid}, 32'h1);
      chk("b2b_add_result", {16'h0, res_data}, 32'h4);
      chk_dbg(3'd6, "b2b_r6");

      // R0 stays zero, result still published
      do_instr(ALU_INC, 3'd0, 3'd0, 3'd0, 1'b0);
      chk("r0_res_data", {16'h0, res_data}, 32'h1);
      dbg_addr = 3'd0;
      #1;
      chk("r0_still_zero", {16'h0, dbg_data}, 32'h0);

      // Overflow, clear, and clear-vs-set priority
      do_instr(ALU_INV, 3'd7, 3'd0, 3'd0, 1'b0);
      do_instr(ALU_SRL, 3'd1, 3'd7, 3'd0, 1'b0);
      do_instr(ALU_INC, 3'd2, 3'd0, 3'd0, 1'b0);
      do_instr(ALU_ADD, 3'd4, 3'd1, 3'd2, 1'b0);
      chk("ovf_res", {16'h0, res_data}, 32'h8000);
      chk("ovf_sticky_set", {31'h0, sticky_ovf}, 32'h1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      msticky   = 1'b0;
      chk("ovf_cleared", {31'h0, sticky_ovf}, 32'h0);
      clr_flags = 1'b1;
      do_instr(ALU_ADD, 3'd5, 3'd1, 3'd2, 1'b0);
      clr_flags = 1'b0;
      chk("ovf_set_wins", {31'h0, sticky_ovf}, 32'h1);
      clr_flags = 1'b1;
      do_instr(ALU_INC, 3'd3, 3'd3, 3'd0, 1'b0);
      clr_flags = 1'b0;
      chk("clr_in_quiet_wb", {31'h0, sticky_ovf}, 32'h0);

      // Random instructions with handshake noise while busy
      for (int n = 0; n < 40; n++) begin
         do_instr(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
      end
      for (int i = 0; i < 8; i++) chk_dbg(3'(i), "final_regs");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
